// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_mode_t;

    localparam int OVRSMPL_DEF = 16;
    localparam int W_WORD_DATA = 8;

    typedef struct packed {
        logic                   framing;
        logic                   parity;
        logic [W_WORD_DATA-1:0] data;
    } rx_word_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through receive FIFO; head reads as zero while empty.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
    logic             do_wr, do_rd;

    assign do_rd   = rd & ~empty;
    assign do_wr   = wr & (~full | do_rd);
    assign overrun = wr & full & ~do_rd;
    assign wptr_n  = do_wr ? wptr + (AW+1)'(1) : wptr;
    assign rptr_n  = do_rd ? rptr + (AW+1)'(1) : rptr;
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            empty <= (wptr_n == rptr_n);
            full  <= (wptr_n[AW] != rptr_n[AW]) &&
                     (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time frame format, error tags, overrun and break.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int W_DATA     = 8,
    parameter int W_DVSR     = 16,
    parameter int OVRSMPL    = OVRSMPL_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_DVSR-1:0] dvsr,
    input  logic [1:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              stop_bits,
    input  logic              Rx_din,
    input  logic              rd_uart,
    input  logic              err_clr,
    output logic [W_DATA-1:0] rd_data,
    output logic              Rx_empty,
    output logic              Rx_full,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overrun_error,
    output logic              break_det
);
    localparam int W_S = $clog2(OVRSMPL);
    localparam int W_N = $clog2(W_DATA);
    localparam logic [W_S-1:0] S_MID = W_S'(OVRSMPL/2 - 1);
    localparam logic [W_S-1:0] S_END = W_S'(OVRSMPL - 1);

    logic              rx_m, rx_s;
    logic [W_DVSR-1:0] tcnt;
    logic              tick;
    rx_state_t         state;
    logic [W_S-1:0]    s;
    logic [W_N-1:0]    n, n_last;
    logic [W_DATA-1:0] dat;
    parity_mode_t      pmode;
    logic              stop2, stop_idx;
    logic              acc, zero, perr, ferr;
    logic              brk_wait, push;
    logic [W_DATA+1:0] word, head;
    logic              fifo_ovr;

    assign tick = (tcnt == dvsr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            tcnt <= '0;
        end else begin
            rx_m <= Rx_din;
            rx_s <= rx_m;
            tcnt <= tick ? '0 : tcnt + W_DVSR'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            s             <= '0;
            n             <= '0;
            n_last        <= '0;
            dat           <= '0;
            pmode         <= NONE;
            stop2         <= 1'b0;
            stop_idx      <= 1'b0;
            acc           <= 1'b0;
            zero          <= 1'b0;
            perr          <= 1'b0;
            ferr          <= 1'b0;
            brk_wait      <= 1'b0;
            push          <= 1'b0;
            word          <= '0;
            overrun_error <= 1'b0;
            break_det     <= 1'b0;
        end else begin
            push <= 1'b0;
            // a set event in the same cycle overrides the clear below
            if (err_clr) begin
                overrun_error <= 1'b0;
                break_det     <= 1'b0;
            end
            if (fifo_ovr)
                overrun_error <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (brk_wait) begin
                        if (rx_s)
                            brk_wait <= 1'b0;
                    end else if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: if (tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state  <= DATA;
                            s      <= '0;
                            n      <= '0;
                            n_last <= W_N'(data_bits) + W_N'(4);
                            pmode  <= (parity_mode == 2'b11) ? NONE
                                      : parity_mode_t'(parity_mode);
                            stop2  <= stop_bits;
                            dat    <= '0;
                            acc    <= 1'b0;
                            zero   <= 1'b1;
                            perr   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        s <= s + W_S'(1);
                    end
                end
                DATA: if (tick) begin
                    if (s == S_END) begin
                        s      <= '0;
                        dat[n] <= rx_s;
                        acc    <= acc ^ rx_s;
                        zero   <= zero & ~rx_s;
                        if (n == n_last) begin
                            state    <= (pmode == NONE) ? STOP : PARITY;
                            stop_idx <= 1'b0;
                            ferr     <= 1'b0;
                        end else begin
                            n <= n + W_N'(1);
                        end
                    end else begin
                        s <= s + W_S'(1);
                    end
                end
                PARITY: if (tick) begin
                    if (s == S_END) begin
                        s     <= '0;
                        perr  <= (pmode == ODD) ? ~(acc ^ rx_s) : (acc ^ rx_s);
                        zero  <= zero & ~rx_s;
                        state <= STOP;
                    end else begin
                        s <= s + W_S'(1);
                    end
                end
                STOP: if (tick) begin
                    if (s == S_END) begin
                        s <= '0;
                        if (!stop_idx && zero && !rx_s) begin
                            break_det <= 1'b1;
                            brk_wait  <= 1'b1;
                            state     <= IDLE;
                        end else if (stop_idx == stop2) begin
                            push  <= 1'b1;
                            word  <= {ferr | ~rx_s, perr, dat};
                            state <= IDLE;
                        end else begin
                            ferr     <= ferr | ~rx_s;
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        s <= s + W_S'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (W_DATA + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (push),
        .rd      (rd_uart),
        .wdata   (word),
        .rdata   (head),
        .empty   (Rx_empty),
        .full    (Rx_full),
        .overrun (fifo_ovr)
    );

    assign rd_data       = head[W_DATA-1:0];
    assign parity_error  = head[W_DATA];
    assign framing_error = head[W_DATA+1];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench: table vectors, corner sequences, random frames vs model.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dvsr = 16'd3;
    logic [1:0]  data_bits = 2'b11;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop_bits = 1'b0;
    logic        Rx_din = 1'b1;
    logic        rd_uart = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rd_data;
    logic        Rx_empty, Rx_full;
    logic        parity_error, framing_error;
    logic        overrun_error, break_det;

    int tests = 0;
    int fails = 0;

    uart_rx_cfg #(
        .W_DATA     (8),
        .W_DVSR     (16),
        .OVRSMPL    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dvsr          (dvsr),
        .data_bits     (data_bits),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits),
        .Rx_din        (Rx_din),
        .rd_uart       (rd_uart),
        .err_clr       (err_clr),
        .rd_data       (rd_data),
        .Rx_empty      (Rx_empty),
        .Rx_full       (Rx_full),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .break_det     (break_det)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         nb;
        logic [1:0] pm;
        logic       st2;
        logic       flip;
        logic       s2;
        logic [7:0] xd;
        logic       xp;
        logic       xf;
    } vec_t;

    vec_t     vt[5];
    rx_word_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic [7:0] mask_of(input int nb);
        return 8'((1 << nb) - 1);
    endfunction

    function automatic logic par_bit(input logic [7:0] d, input int nb,
                                     input logic [1:0] pm, input logic flip);
        logic [7:0] dm;
        dm = d & mask_of(nb);
        return ((pm == 2'b10) ? ~(^dm) : ^dm) ^ flip;
    endfunction

    function automatic rx_word_t model(input logic [7:0] d, input int nb,
                                       input logic [1:0] pm, input logic st2,
                                       input logic pbit, input logic s2);
        rx_word_t w;
        w.data    = d & mask_of(nb);
        w.parity  = (pm == 2'b01) ? (^w.data ^ pbit)
                  : (pm == 2'b10) ? ~(^w.data ^ pbit) : 1'b0;
        w.framing = st2 & ~s2;
        return w;
    endfunction

    task automatic send_frame(input logic [7:0] d, input int nb,
                              input logic [1:0] pm, input logic st2,
                              input logic pbit, input logic s2);
        data_bits   = 2'(nb - 5);
        parity_mode = pm;
        stop_bits   = st2;
        Rx_din = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < nb; i++) begin
            Rx_din = d[i];
            wait_clk(BIT);
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            Rx_din = pbit;
            wait_clk(BIT);
        end
        Rx_din = 1'b1;
        wait_clk(BIT);
        if (st2) begin
            // a bad stop bit is released just past its mid-bit sample
            Rx_din = s2;
            wait_clk(40);
            Rx_din = 1'b1;
            wait_clk(BIT - 40);
        end
        Rx_din = 1'b1;
        wait_clk(8);
    endtask

    task automatic send8n1(input logic [7:0] d);
        send_frame(d, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] xd,
                              input logic xp, input logic xf);
        check({name, ".empty"}, 32'(Rx_empty), 32'd0);
        check({name, ".data"}, 32'(rd_data), 32'(xd));
        check({name, ".perr"}, 32'(parity_error), 32'(xp));
        check({name, ".ferr"}, 32'(framing_error), 32'(xf));
        pop();
    endtask

    task automatic check_reset_vals(input string name);
        check({name, ".data"}, 32'(rd_data), 32'd0);
        check({name, ".empty"}, 32'(Rx_empty), 32'd1);
        check({name, ".full"}, 32'(Rx_full), 32'd0);
        check({name, ".flags"},
              32'({parity_error, framing_error, overrun_error, break_det}),
              32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         nb;
        logic [1:0] pm;
        logic       st2, flip, s2, pbit;
        rx_word_t   w;

        vt[0] = '{8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{8'h35, 7, 2'b10, 1'b0, 1'b0, 1'b1, 8'h35, 1'b0, 1'b0};
        vt[2] = '{8'h35, 7, 2'b10, 1'b0, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0};
        vt[3] = '{8'h1F, 5, 2'b01, 1'b1, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b1};
        vt[4] = '{8'h1F, 5, 2'b01, 1'b1, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};

        wait_clk(4);
        check_reset_vals("reset");
        rst = 1'b0;
        wait_clk(BIT);

        for (int i = 0; i < 5; i++) begin
            send_frame(vt[i].d, vt[i].nb, vt[i].pm, vt[i].st2,
                       par_bit(vt[i].d, vt[i].nb, vt[i].pm, vt[i].flip),
                       vt[i].s2);
            read_check($sformatf("vec%0d", i), vt[i].xd, vt[i].xp, vt[i].xf);
            check($sformatf("vec%0d.drained", i), 32'(Rx_empty), 32'd1);
        end

        for (int i = 1; i <= 4; i++)
            send8n1(8'(i));
        check("ovr.full", 32'(Rx_full), 32'd1);
        check("ovr.pre", 32'(overrun_error), 32'd0);
        send8n1(8'h05);
        check("ovr.set", 32'(overrun_error), 32'd1);
        check("ovr.still_full", 32'(Rx_full), 32'd1);
        for (int i = 1; i <= 4; i++)
            read_check($sformatf("ovr.rd%0d", i), 8'(i), 1'b0, 1'b0);
        check("ovr.empty", 32'(Rx_empty), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovr.clr", 32'(overrun_error), 32'd0);

        Rx_din = 1'b0;
        wait_clk(12 * BIT);
        Rx_din = 1'b1;
        wait_clk(2 * BIT);
        check("brk.set", 32'(break_det), 32'd1);
        check("brk.empty", 32'(Rx_empty), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("brk.clr", 32'(break_det), 32'd0);

        Rx_din = 1'b0;
        wait_clk(16);
        Rx_din = 1'b1;
        wait_clk(3 * BIT);
        check("glitch.empty", 32'(Rx_empty), 32'd1);
        send8n1(8'h5A);
        read_check("post_glitch", 8'h5A, 1'b0, 1'b0);

        send8n1(8'h77);
        d = 8'h3C;
        Rx_din = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 3; i++) begin
            Rx_din = d[i];
            wait_clk(BIT);
        end
        Rx_din = d[3];
        wait_clk(BIT / 2);
        rst = 1'b1;
        Rx_din = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrst");
        wait_clk(2 * BIT);
        send8n1(8'h3C);
        read_check("post_rst", 8'h3C, 1'b0, 1'b0);
        check("post_rst.empty", 32'(Rx_empty), 32'd1);

        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 3; k++) begin
                d    = 8'($urandom);
                nb   = int'($urandom_range(5, 8));
                pm   = 2'($urandom_range(0, 3));
                st2  = 1'($urandom_range(0, 1));
                flip = 1'($urandom_range(0, 1));
                s2   = st2 ? 1'($urandom_range(0, 1)) : 1'b1;
                pbit = par_bit(d, nb, pm, flip);
                send_frame(d, nb, pm, st2, pbit, s2);
                exp_q.push_back(model(d, nb, pm, st2, pbit, s2));
            end
            while (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                read_check($sformatf("rand%0d", g), w.data, w.parity,
                           w.framing);
            end
            check($sformatf("rand%0d.empty", g), 32'(Rx_empty), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
